// File: rtl/rect_draw_sequencer_if.sv
// Pixel-sequencer bus: frame handshake, background ROM port, sprite table and pixel output.
// master = sequencer side, slave = game logic / ROM / vga_adapter side.
interface rect_draw_sequencer_if #(
    parameter int unsigned XW   = 8,
    parameter int unsigned YW   = 7,
    parameter int unsigned NSPR = 4,
    parameter int unsigned SW_W = 5,
    parameter int unsigned CW   = 3,
    parameter int unsigned AW   = 15
);
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [AW-1:0]          bg_addr;
    logic [CW-1:0]          bg_colour;
    logic [NSPR*XW-1:0]     spr_x;
    logic [NSPR*YW-1:0]     spr_y;
    logic [NSPR*SW_W-1:0]   spr_w;
    logic [NSPR*SW_W-1:0]   spr_h;
    logic [NSPR*CW-1:0]     spr_colour;
    logic [NSPR-1:0]        spr_en;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [CW-1:0]          colour;
    logic                   plot;

    modport master (
        input  start, bg_colour, spr_x, spr_y, spr_w, spr_h, spr_colour, spr_en,
        output busy, done, bg_addr, x, y, colour, plot
    );

    modport slave (
        output start, bg_colour, spr_x, spr_y, spr_w, spr_h, spr_colour, spr_en,
        input  busy, done, bg_addr, x, y, colour, plot
    );
endinterface

// File: rtl/rect_draw_sequencer.sv
// Per-frame pixel sequencer: background sweep from a 1-cycle ROM, then NSPR solid rectangles.
// Optional macro RECT_DRAW_CLIP_EN suppresses plot for off-screen sprite pixels instead of wrapping.
module rect_draw_sequencer #(
    parameter int unsigned XMAX = 160,
    parameter int unsigned YMAX = 120,
    parameter int unsigned XW   = 8,
    parameter int unsigned YW   = 7,
    parameter int unsigned NSPR = 4,
    parameter int unsigned SW_W = 5,
    parameter int unsigned CW   = 3,
    parameter int unsigned AW   = 15
) (
    input logic                   clock,
    input logic                   resetn,
    rect_draw_sequencer_if.master bus
);
    localparam int unsigned IW = (NSPR > 1) ? $clog2(NSPR) : 1;
`ifdef RECT_DRAW_CLIP_EN
    // Carry bit is what detects the off-screen pixels.
    localparam int unsigned SXW = XW + 1;
    localparam int unsigned SYW = YW + 1;
`else
    localparam int unsigned SXW = XW;
    localparam int unsigned SYW = YW;
`endif

    typedef enum logic [1:0] {StIdle, StBg, StSpr, StFlush} state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     bx_q, bx_d;
    logic [YW-1:0]     by_q, by_d;
    logic [SW_W-1:0]   wc_q, wc_d;
    logic [SW_W-1:0]   hc_q, hc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [XW-1:0]     px_q, px_d;
    logic [YW-1:0]     py_q, py_d;
    logic [CW-1:0]     pcol_q, pcol_d;
    logic              plot_q, plot_d;
    logic              bgsel_q, bgsel_d;
    logic              done_q, done_d;
    logic              snap_en;

    logic [XW-1:0]     sx_q   [NSPR];
    logic [YW-1:0]     sy_q   [NSPR];
    logic [SW_W-1:0]   sw_q   [NSPR];
    logic [SW_W-1:0]   sh_q   [NSPR];
    logic [CW-1:0]     scol_q [NSPR];
    logic              sen_q  [NSPR];

    logic [XW-1:0]     cur_x;
    logic [YW-1:0]     cur_y;
    logic [SW_W-1:0]   cur_w;
    logic [SW_W-1:0]   cur_h;
    logic [CW-1:0]     cur_col;
    logic              cur_act;
    logic              last_px;
    logic [SXW-1:0]    sum_x;
    logic [SYW-1:0]    sum_y;

    assign cur_x   = sx_q[idx_q];
    assign cur_y   = sy_q[idx_q];
    assign cur_w   = sw_q[idx_q];
    assign cur_h   = sh_q[idx_q];
    assign cur_col = scol_q[idx_q];
    assign cur_act = sen_q[idx_q] && (cur_w != '0) && (cur_h != '0);
    assign last_px = (wc_q == cur_w - 1'b1) && (hc_q == cur_h - 1'b1);
    assign sum_x   = SXW'(cur_x) + SXW'(wc_q);
    assign sum_y   = SYW'(cur_y) + SYW'(hc_q);

    assign bus.bg_addr = AW'(by_q) * AW'(XMAX) + AW'(bx_q);
    assign bus.x       = px_q;
    assign bus.y       = py_q;
    // ROM data arrives in the same cycle as its registered coordinates.
    assign bus.colour  = bgsel_q ? bus.bg_colour : pcol_q;
    assign bus.plot    = plot_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        wc_d    = wc_q;
        hc_d    = hc_q;
        idx_d   = idx_q;
        px_d    = px_q;
        py_d    = py_q;
        pcol_d  = pcol_q;
        plot_d  = 1'b0;
        bgsel_d = 1'b0;
        done_d  = 1'b0;
        snap_en = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StBg;
                    bx_d    = '0;
                    by_d    = '0;
                    snap_en = 1'b1;
                end
            end
            StBg: begin
                px_d    = bx_q;
                py_d    = by_q;
                plot_d  = 1'b1;
                bgsel_d = 1'b1;
                if (bx_q == XW'(XMAX - 1)) begin
                    bx_d = '0;
                    if (by_q == YW'(YMAX - 1)) begin
                        state_d = StSpr;
                        idx_d   = '0;
                        wc_d    = '0;
                        hc_d    = '0;
                    end else begin
                        by_d = by_q + 1'b1;
                    end
                end else begin
                    bx_d = bx_q + 1'b1;
                end
            end
            StSpr: begin
                if (cur_act) begin
                    px_d   = sum_x[XW-1:0];
                    py_d   = sum_y[YW-1:0];
                    pcol_d = cur_col;
`ifdef RECT_DRAW_CLIP_EN
                    plot_d = (sum_x < SXW'(XMAX)) && (sum_y < SYW'(YMAX));
`else
                    plot_d = 1'b1;
`endif
                    if (wc_q == cur_w - 1'b1) begin
                        wc_d = '0;
                        hc_d = hc_q + 1'b1;
                    end else begin
                        wc_d = wc_q + 1'b1;
                    end
                end
                // Inactive sprites burn exactly one cycle.
                if (!cur_act || last_px) begin
                    wc_d = '0;
                    hc_d = '0;
                    if (idx_q == IW'(NSPR - 1)) begin
                        state_d = StFlush;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= StIdle;
            bx_q    <= '0;
            by_q    <= '0;
            wc_q    <= '0;
            hc_q    <= '0;
            idx_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            pcol_q  <= '0;
            plot_q  <= 1'b0;
            bgsel_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            wc_q    <= wc_d;
            hc_q    <= hc_d;
            idx_q   <= idx_d;
            px_q    <= px_d;
            py_q    <= py_d;
            pcol_q  <= pcol_d;
            plot_q  <= plot_d;
            bgsel_q <= bgsel_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (snap_en) begin
            for (int unsigned i = 0; i < NSPR; i++) begin
                sx_q[i]   <= bus.spr_x[i*XW +: XW];
                sy_q[i]   <= bus.spr_y[i*YW +: YW];
                sw_q[i]   <= bus.spr_w[i*SW_W +: SW_W];
                sh_q[i]   <= bus.spr_h[i*SW_W +: SW_W];
                scol_q[i] <= bus.spr_colour[i*CW +: CW];
                sen_q[i]  <= bus.spr_en[i];
            end
        end
    end
endmodule
